rr_arb2: RTL

RR_ARB2 -- requirements
Module: rr_arb2

---
 rtl/rr_arb2_if.sv | 31 +++
 rtl/rr_arb2.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rr_arb2_if.sv
// ============================================================================
//  Module   : rr_arb2_if
//  Purpose  : Request/done/grant bundle between two requesters and rr_arb2.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rr_arb2_if;
    logic a_req_i;
    logic a_done_i;
    logic b_req_i;
    logic b_done_i;
    logic a_gnt_o;
    logic b_gnt_o;
    logic busy_o;
    logic timeout_o;

    // Arbiter side
    modport slave (
        input  a_req_i, a_done_i, b_req_i, b_done_i,
        output a_gnt_o, b_gnt_o, busy_o, timeout_o
    );

    // Requester side
    modport master (
        output a_req_i, a_done_i, b_req_i, b_done_i,
        input  a_gnt_o, b_gnt_o, busy_o, timeout_o
    );
endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-requester round-robin arbiter with registered grants.
//             Define RR_ARB2_TIMEOUT_EN to force release after MAX_HOLD cycles.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    rr_arb2_if.slave  arb
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    generate
        if ((MAX_HOLD < 2) || (MAX_HOLD > 256)) begin : g_bad_max_hold
            $error("rr_arb2: MAX_HOLD must be within 2..256");
        end
    endgenerate

    state_t state_q, state_d;
    logic   last_b_q, last_b_d;
    logic   a_gnt_q, a_gnt_d;
    logic   b_gnt_q, b_gnt_d;
    logic   busy_q, busy_d;
    logic   grant_entry;
    logic   release_w;
    logic   hold_expired;

    // Owner gives up the resource by pulsing done or dropping its request.
    always_comb begin
        release_w = 1'b0;
        case (state_q)
            ST_GNT_A: release_w = arb.a_done_i || !arb.a_req_i;
            ST_GNT_B: release_w = arb.b_done_i || !arb.b_req_i;
            default:  release_w = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        grant_entry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb.a_req_i && (!arb.b_req_i || last_b_q)) begin
                    state_d     = ST_GNT_A;
                    last_b_d    = 1'b0;
                    grant_entry = 1'b1;
                end else if (arb.b_req_i) begin
                    state_d     = ST_GNT_B;
                    last_b_d    = 1'b1;
                    grant_entry = 1'b1;
                end
            end
            ST_GNT_A: begin
                if (release_w || hold_expired) begin
                    if (arb.b_req_i) begin
                        state_d     = ST_GNT_B;
                        last_b_d    = 1'b1;
                        grant_entry = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GNT_B: begin
                if (release_w || hold_expired) begin
                    if (arb.a_req_i) begin
                        state_d     = ST_GNT_A;
                        last_b_d    = 1'b0;
                        grant_entry = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        a_gnt_d = (state_d == ST_GNT_A);
        b_gnt_d = (state_d == ST_GNT_B);
        busy_d  = a_gnt_d || b_gnt_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            last_b_q <= 1'b1;
            a_gnt_q  <= 1'b0;
            b_gnt_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            a_gnt_q  <= a_gnt_d;
            b_gnt_q  <= b_gnt_d;
            busy_q   <= busy_d;
        end
    end

`ifdef RR_ARB2_TIMEOUT_EN
    localparam int unsigned        CNT_W       = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0]   C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    // Tenure counter restarts on every new owner, including direct handoff.
    always_comb begin
        hold_cnt_d = '0;
        if (!grant_entry && (state_d != ST_IDLE)) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    assign hold_expired = (hold_cnt_q == C_HOLD_LAST);

    // A voluntary release in the expiry cycle is not reported as a timeout.
    always_comb begin
        timeout_d = hold_expired && !release_w && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign arb.timeout_o = timeout_q;
`else
    assign hold_expired  = 1'b0;
    assign arb.timeout_o = 1'b0;
`endif

    assign arb.a_gnt_o = a_gnt_q;
    assign arb.b_gnt_o = b_gnt_q;
    assign arb.busy_o  = busy_q;

endmodule

`default_nettype wire
